char_glyph_server: RTL and testbench

//  Responder side of the character-display read interface (readEn/rowCnt/colCnt -> bitDisp).
//  On each readEn request, fetches one 8-bit glyph row of the current charCode from an external font ROM over a req/ack handshake.

---
 rtl/char_glyph_pkg.sv | 22 ++
 rtl/char_glyph_server_glyph_row_buffer.sv | 58 +++++
 rtl/char_glyph_server.sv | 165 ++++++++++++++++
 tb/tb_char_glyph_server.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/char_glyph_pkg.sv
// Shared types and helpers for the glyph server: fetch FSM states, glyph
// geometry and the {code,row} font ROM address packing.
package char_glyph_pkg;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;
  localparam int ROW_W   = $clog2(GLYPH_H);
  localparam int ROM_AW  = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_LOAD,
    ST_ERR
  } fetch_state_t;

  function automatic logic [ROM_AW-1:0] rom_addr_pack(input logic [7:0] code,
                                                      input logic [ROW_W-1:0] row);
    return {code, row};
  endfunction

endpackage

// File: rtl/char_glyph_server_glyph_row_buffer.sv
// Pending/active glyph row double buffer with column-0 promotion and the
// registered pixel bit selected by colCnt.
module glyph_row_buffer
  import char_glyph_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pend_wr,
  input  logic [GLYPH_W-1:0] pend_data,
  input  logic               pend_set,
  input  logic [2:0]         colCnt,
  output logic               bitDisp,
  output logic               glyphValid
);

  logic [GLYPH_W-1:0] pend_buf_reg;
  logic [GLYPH_W-1:0] active_buf_reg;
  logic               pend_valid_reg;
  logic               glyph_valid_reg;
  logic               bit_disp_reg;
  logic               promote;
  logic [2:0]         bit_idx;

  // Only swap at the start of a row so the displayed row is never torn.
  assign promote = pend_valid_reg && (colCnt == 3'd0);
  assign bit_idx = MSB_FIRST ? (3'd7 - colCnt) : colCnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_buf_reg    <= '0;
      active_buf_reg  <= '0;
      pend_valid_reg  <= 1'b0;
      glyph_valid_reg <= 1'b0;
      bit_disp_reg    <= 1'b0;
    end else begin
      bit_disp_reg <= glyph_valid_reg ? active_buf_reg[bit_idx] : 1'b0;
      if (promote) begin
        active_buf_reg  <= pend_buf_reg;
        glyph_valid_reg <= 1'b1;
      end
      if (pend_wr) begin
        pend_buf_reg <= pend_data;
      end
      // A fresh write wins over the clear from a same-cycle promotion.
      if (pend_wr || pend_set) begin
        pend_valid_reg <= 1'b1;
      end else if (promote) begin
        pend_valid_reg <= 1'b0;
      end
    end
  end

  assign bitDisp    = bit_disp_reg;
  assign glyphValid = glyph_valid_reg;

endmodule

// File: rtl/char_glyph_server.sv
// Character glyph server: readEn edge detect, 1-deep request queue, font ROM
// req/ack FSM with timeout. Optional underline row via CHAR_UNDERLINE_EN.
module char_glyph_server
  import char_glyph_pkg::*;
#(
  parameter int ROM_TIMEOUT = 15,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               readEn,
  input  logic [ROW_W-1:0]   rowCnt,
  input  logic [2:0]         colCnt,
  input  logic [7:0]         charCode,
`ifdef CHAR_UNDERLINE_EN
  input  logic               underline,
`endif
  output logic               romReq,
  output logic [ROM_AW-1:0]  romAddr,
  input  logic               romAck,
  input  logic [GLYPH_W-1:0] romData,
  output logic               bitDisp,
  output logic               glyphValid,
  output logic               fetchErr,
  output logic               overrun
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(ROM_TIMEOUT);

`ifdef CHAR_UNDERLINE_EN
  localparam int TAG_W = ROM_AW + 1;
`else
  localparam int TAG_W = ROM_AW;
`endif

  fetch_state_t       state_reg, state_next;
  logic               en_q_reg;
  logic [TAG_W-1:0]   req_tag_reg, q_tag_reg, new_tag;
  logic               queued_reg, fetch_err_reg, overrun_reg;
  logic [7:0]         cnt_reg, cnt_inc;
  logic               req_pulse, queue_push, start_new, start_queued;
  logic               pend_wr, pend_set, err_set;
  logic [GLYPH_W-1:0] pend_data, load_data;

  assign req_pulse  = readEn & ~en_q_reg;
  assign queue_push = req_pulse & ~start_new;
  assign cnt_inc    = (cnt_reg == 8'hFF) ? cnt_reg : cnt_reg + 8'd1;

`ifdef CHAR_UNDERLINE_EN
  // Tag MSB carries the underline flag alongside the ROM address.
  assign new_tag   = {underline, rom_addr_pack(charCode, rowCnt)};
  assign load_data = (req_tag_reg[ROM_AW] && req_tag_reg[ROW_W-1:0] == ROW_W'(GLYPH_H - 1))
                     ? {GLYPH_W{1'b1}} : romData;
`else
  assign new_tag   = rom_addr_pack(charCode, rowCnt);
  assign load_data = romData;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    romReq       = 1'b0;
    pend_wr      = 1'b0;
    pend_set     = 1'b0;
    pend_data    = load_data;
    err_set      = 1'b0;
    start_new    = 1'b0;
    start_queued = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // The queued (older) request is served before a new edge.
        if (queued_reg) begin
          start_queued = 1'b1;
          state_next   = ST_REQ;
        end else if (req_pulse) begin
          start_new  = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        romReq = 1'b1;
        if (romAck) begin
          pend_wr    = 1'b1;
          state_next = ST_LOAD;
        end else if (cnt_inc >= TIMEOUT_CNT) begin
          state_next = ST_ERR;
        end
      end
      ST_LOAD: begin
        pend_set   = 1'b1;
        state_next = ST_IDLE;
      end
      ST_ERR: begin
        pend_wr    = 1'b1;
        pend_data  = '0;
        pend_set   = 1'b1;
        err_set    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      en_q_reg      <= 1'b0;
      req_tag_reg   <= '0;
      q_tag_reg     <= '0;
      queued_reg    <= 1'b0;
      cnt_reg       <= '0;
      fetch_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      en_q_reg <= readEn;
      if (start_queued) begin
        req_tag_reg <= q_tag_reg;
        cnt_reg     <= '0;
      end else if (start_new) begin
        req_tag_reg <= new_tag;
        cnt_reg     <= '0;
      end else if (state_reg == ST_REQ) begin
        cnt_reg <= cnt_inc;
      end
      // A queue entry being consumed this cycle frees the slot for the new edge.
      if (queue_push) begin
        if (queued_reg && !start_queued) begin
          overrun_reg <= 1'b1;
        end else begin
          queued_reg <= 1'b1;
          q_tag_reg  <= new_tag;
        end
      end else if (start_queued) begin
        queued_reg <= 1'b0;
      end
      if (err_set) begin
        fetch_err_reg <= 1'b1;
      end
    end
  end

  assign romAddr  = req_tag_reg[ROM_AW-1:0];
  assign fetchErr = fetch_err_reg;
  assign overrun  = overrun_reg;

  glyph_row_buffer #(
    .MSB_FIRST(MSB_FIRST)
  ) u_row_buf (
    .clock     (clock),
    .reset     (reset),
    .pend_wr   (pend_wr),
    .pend_data (pend_data),
    .pend_set  (pend_set),
    .colCnt    (colCnt),
    .bitDisp   (bitDisp),
    .glyphValid(glyphValid)
  );

endmodule

// File: tb/tb_char_glyph_server.sv
// Bench for char_glyph_server: directed scenarios then random traffic, all
// checked every cycle against a behavioural request/row model.
module tb_char_glyph_server;

  localparam int  TMO = 15;
  localparam bit  MSB = 1'b1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        readEn = 1'b0;
  logic [3:0]  rowCnt = '0;
  logic [2:0]  colCnt = '0;
  logic [7:0]  charCode = '0;
  logic        romAck = 1'b0;
  logic [7:0]  romData = '0;
`ifdef CHAR_UNDERLINE_EN
  logic        underline = 1'b0;
`endif
  logic        romReq;
  logic [11:0] romAddr;
  logic        bitDisp, glyphValid, fetchErr, overrun;

  char_glyph_server #(.ROM_TIMEOUT(TMO), .MSB_FIRST(MSB)) dut (
    .clock(clock), .reset(reset), .readEn(readEn), .rowCnt(rowCnt),
    .colCnt(colCnt), .charCode(charCode),
`ifdef CHAR_UNDERLINE_EN
    .underline(underline),
`endif
    .romReq(romReq), .romAddr(romAddr), .romAck(romAck), .romData(romData),
    .bitDisp(bitDisp), .glyphValid(glyphValid), .fetchErr(fetchErr),
    .overrun(overrun)
  );

  always #5 clock = ~clock;

  // Reference model: a request being served, a one-slot waiting list,
  // and the row shown on screen versus the row waiting to be shown.
  bit          m_en_q;
  int          m_phase;        // 0 nothing in flight, 1 waiting on ROM, 2 row arrived, 3 ROM gave up
  int          m_age;
  logic [12:0] m_cur;
  logic [12:0] m_wait[$];
  bit          m_err, m_ovr, m_pv, m_gv, m_bit;
  logic [7:0]  m_pend, m_shown;

  int          ack_delay = 99;
  bit          rand_mode = 1'b0;
  bit          col_run = 1'b0;
  logic [7:0]  rom_byte = '0;
  bit          last_req = 1'b0;
  logic [11:0] seen[$];
  int          n_checks = 0;
  int          n_fails = 0;

  function automatic logic [12:0] cur_tag();
`ifdef CHAR_UNDERLINE_EN
    return {underline, charCode, rowCnt};
`else
    return {1'b0, charCode, rowCnt};
`endif
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_en_q = 0; m_phase = 0; m_age = 0; m_cur = '0; m_wait.delete();
    m_err = 0; m_ovr = 0; m_pv = 0; m_gv = 0; m_bit = 0;
    m_pend = '0; m_shown = '0; last_req = 0;
  endtask

  task automatic model_step();
    automatic bit         pulse = readEn && !m_en_q;
    automatic bit         used = 0, wrote = 0, landed = 0;
    automatic logic [7:0] wval = '0;
    automatic bit         swap = m_pv && (colCnt == 3'd0);
    automatic int         col = int'(colCnt);
    automatic int         idx = MSB ? 7 - col : col;
    automatic bit         begin_fetch = 0;
    if (m_phase == 0) begin
      if (m_wait.size() > 0) begin
        m_cur = m_wait.pop_front(); begin_fetch = 1;
      end else if (pulse) begin
        m_cur = cur_tag(); used = 1; begin_fetch = 1;
      end
      if (begin_fetch) begin
        m_phase = 1; m_age = 0;
        if (rand_mode) ack_delay = $urandom_range(0, TMO + 3);
      end
    end else if (m_phase == 1) begin
      if (romAck) begin
        wrote = 1; m_phase = 2;
        wval = (m_cur[12] && m_cur[3:0] == 4'd15) ? 8'hFF : romData;
      end else begin
        m_age++;
        if (m_age >= TMO) m_phase = 3;
      end
    end else if (m_phase == 2) begin
      landed = 1; m_phase = 0;
    end else begin
      wrote = 1; wval = 8'h00; landed = 1; m_err = 1; m_phase = 0;
    end
    if (pulse && !used) begin
      if (m_wait.size() > 0) m_ovr = 1;
      else m_wait.push_back(cur_tag());
    end
    m_bit = m_gv ? m_shown[idx] : 1'b0;
    if (swap) begin m_shown = m_pend; m_gv = 1; end
    if (wrote) m_pend = wval;
    if (wrote || landed) m_pv = 1;
    else if (swap) m_pv = 0;
    m_en_q = readEn;
  endtask

  task automatic cycle();
    if (col_run) colCnt = colCnt + 3'd1;
    romAck  = (m_phase == 1) && (m_age == ack_delay);
    romData = rand_mode ? 8'($urandom) : (romAck ? rom_byte : 8'h5A);
    @(posedge clock);
    model_step();
    #2;
    check("romReq", romReq, m_phase == 1);
    if (m_phase == 1) check("romAddr", romAddr, m_cur[11:0]);
    check("bitDisp", bitDisp, m_bit);
    check("glyphValid", glyphValid, m_gv);
    check("fetchErr", fetchErr, m_err);
    check("overrun", overrun, m_ovr);
    if (romReq && !last_req) seen.push_back(romAddr);
    last_req = romReq;
  endtask

  task automatic wait_idle(input int limit);
    automatic int k = 0;
    while ((m_phase != 0 || m_wait.size() != 0) && k < limit) begin
      cycle(); k++;
    end
    check("wait_idle_bound", k < limit, 1'b1);
  endtask

  task automatic sweep(input string tag, input bit do_check, input logic [7:0] row);
    col_run = 0;
    for (int c = 0; c < 8; c++) begin
      colCnt = 3'(c);
      cycle();
      if (do_check) check(tag, bitDisp, row[7 - c]);
    end
  endtask

  task automatic fetch(input logic [7:0] code, input logic [3:0] row, input int dly, input logic [7:0] data);
    readEn = 0; cycle();
    charCode = code; rowCnt = row; ack_delay = dly; rom_byte = data; readEn = 1;
    cycle();
  endtask

  initial begin
    model_reset();
    #1 reset = 0;
    #1;
    check("rst_romReq", romReq, 1'b0);
    check("rst_bitDisp", bitDisp, 1'b0);
    check("rst_glyphValid", glyphValid, 1'b0);
    check("rst_fetchErr", fetchErr, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    @(posedge clock); @(posedge clock); #2 reset = 1;

    // Basic fetch of 'A' row 5, ack after 3 cycles with A5.
    colCnt = 0; col_run = 0;
    fetch(8'h41, 4'd5, 3, 8'hA5);
    check("t1_addr", romAddr, 12'h415);
    wait_idle(50);
    cycle();
    sweep("t1_row", 1'b1, 8'hA5);

    // Row lands while colCnt sits at 3: displayed bit must not change.
    colCnt = 3;
    fetch(8'h22, 4'd1, 2, 8'h10);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("t4_hold", bitDisp, 1'b0);
    end
    colCnt = 0; cycle();
    colCnt = 3; cycle();
    check("t4_new", bitDisp, 1'b1);

    // ROM never answers.
    begin
      automatic int req_cycles = 0;
      col_run = 1;
      fetch(8'h33, 4'd2, 99, 8'h00);
      req_cycles = 1;
      for (int i = 0; i < 40; i++) begin
        cycle();
        if (romReq) req_cycles++;
      end
      check("t2_req_cycles", 16'(req_cycles), 16'd15);
      check("t2_fetchErr", fetchErr, 1'b1);
      sweep("t2_row_a", 1'b0, 8'h00);
      sweep("t2_row_b", 1'b1, 8'h00);
    end

    // Three edges while busy: second served, third dropped.
    seen.delete();
    readEn = 0; cycle();
    ack_delay = 8; rom_byte = 8'h3C;
    {charCode, rowCnt} = 12'h7A3; readEn = 1; cycle();
    readEn = 0; cycle();
    {charCode, rowCnt} = 12'h1C6; readEn = 1; cycle();
    readEn = 0; cycle();
    {charCode, rowCnt} = 12'h2E9; readEn = 1; cycle();
    readEn = 0; cycle();
    wait_idle(100);
    check("t3_served", 16'(seen.size()), 16'd2);
    if (seen.size() == 2) begin
      check("t3_first", seen[0], 12'h7A3);
      check("t3_second", seen[1], 12'h1C6);
    end
    check("t3_overrun", overrun, 1'b1);

    // Asynchronous reset in the middle of a handshake.
    fetch(8'h55, 4'd7, 99, 8'h00);
    cycle(); cycle();
    #1 reset = 0;
    #1;
    check("t5_romReq", romReq, 1'b0);
    check("t5_bitDisp", bitDisp, 1'b0);
    check("t5_glyphValid", glyphValid, 1'b0);
    check("t5_fetchErr", fetchErr, 1'b0);
    check("t5_overrun", overrun, 1'b0);
    model_reset();
    readEn = 0;
    @(posedge clock); @(posedge clock); #2 reset = 1;
    fetch(8'h66, 4'd9, 2, 8'hC3);
    check("t5_addr", romAddr, 12'h669);
    wait_idle(50);
    cycle();
    sweep("t5_row_a", 1'b0, 8'h00);
    sweep("t5_row_b", 1'b1, 8'hC3);

`ifdef CHAR_UNDERLINE_EN
    underline = 1;
    fetch(8'h12, 4'd15, 1, 8'h00);
    wait_idle(50);
    sweep("ul_row_a", 1'b0, 8'h00);
    sweep("ul_on", 1'b1, 8'hFF);
    underline = 0;
    fetch(8'h12, 4'd15, 1, 8'h00);
    wait_idle(50);
    sweep("ul_row_c", 1'b0, 8'h00);
    sweep("ul_off", 1'b1, 8'h00);
`endif

    // Random traffic against the model.
    rand_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) readEn = ~readEn;
      charCode = 8'($urandom);
      rowCnt   = 4'($urandom);
`ifdef CHAR_UNDERLINE_EN
      underline = 1'($urandom);
`endif
      col_run = ($urandom_range(0, 9) != 0);
      if (!col_run) colCnt = 3'($urandom);
      cycle();
    end
    readEn = 0;
    wait_idle(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
